// File: rtl/gp_dbg_pkg.sv
// Shared types and defaults for the GenerateProof deadlock debug path.
package gp_dbg_pkg;

  localparam int unsigned NMonDefault = 8;
  localparam int unsigned CntWDefault = 16;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StReport,
    StHold
  } dbg_state_e;

  // (a + b) mod n, used to walk monitor indices in round-robin order.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/gp_rr_pick.sv
// Round-robin picker: first set bit of mask_i at or after ptr_i, wrapping mod N_MON.
module gp_rr_pick
  import gp_dbg_pkg::*;
#(
  parameter int unsigned N_MON = NMonDefault,
  parameter int unsigned IDX_W = $clog2(N_MON)
) (
  input  logic [N_MON-1:0] mask_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o
);

  // Walk from farthest to nearest so the closest set bit to ptr_i is written last.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = N_MON; i > 0; i--) begin
      if (mask_i[IDX_W'(wrap_add(32'(ptr_i), i - 1, N_MON))]) begin
        idx_o = IDX_W'(wrap_add(32'(ptr_i), i - 1, N_MON));
      end
    end
  end

endmodule

// File: rtl/gp_deadlock_report_ctrl.sv
// Collects HLS deadlock monitor block flags, qualifies persistence, reports one instance RR.
// Optional feature: DEADLOCK_DURATION_EN adds rpt_cycles_o (continuous blocked duration).
module gp_deadlock_report_ctrl
  import gp_dbg_pkg::*;
#(
  parameter int unsigned N_MON          = NMonDefault,
  parameter int unsigned IDX_W          = $clog2(N_MON),
  parameter int unsigned PERSIST_CYCLES = 16,
  parameter int unsigned CNT_W          = CntWDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [N_MON-1:0] block_sigs_i,
  input  logic             clear_i,
  output logic             rpt_valid_o,
  input  logic             rpt_ready_i,
  output logic [IDX_W-1:0] rpt_idx_o,
  output logic [N_MON-1:0] rpt_mask_o,
`ifdef DEADLOCK_DURATION_EN
  output logic [CNT_W-1:0] rpt_cycles_o,
`endif
  output logic             deadlock_o
);

  dbg_state_e       state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] rpt_idx_q, rpt_idx_d;
  logic [N_MON-1:0] rpt_mask_q, rpt_mask_d;
  logic             rpt_valid_q, rpt_valid_d;
  logic             deadlock_q, deadlock_d;
  logic [IDX_W-1:0] pick_idx;
  logic             any_blk;
  logic             capture;

  assign any_blk = |block_sigs_i;

  gp_rr_pick #(
    .N_MON(N_MON),
    .IDX_W(IDX_W)
  ) u_rr_pick (
    .mask_i(block_sigs_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    rr_ptr_d    = rr_ptr_q;
    rpt_idx_d   = rpt_idx_q;
    rpt_mask_d  = rpt_mask_q;
    rpt_valid_d = rpt_valid_q;
    capture     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (enable_i && any_blk) begin
          if (PERSIST_CYCLES == 1) begin
            capture = 1'b1;
          end else begin
            state_d = StArmed;
            pcnt_d  = CNT_W'(1);
          end
        end else begin
          pcnt_d = '0;
        end
      end
      StArmed: begin
        if (!enable_i || !any_blk) begin
          state_d = StIdle;
          pcnt_d  = '0;
        end else begin
          pcnt_d = (pcnt_q == '1) ? pcnt_q : pcnt_q + CNT_W'(1);
          if (pcnt_q == CNT_W'(PERSIST_CYCLES - 1)) begin
            capture = 1'b1;
          end
        end
      end
      StReport: begin
        if (rpt_valid_q && rpt_ready_i) begin
          rr_ptr_d    = (rpt_idx_q == IDX_W'(N_MON - 1)) ? '0 : rpt_idx_q + IDX_W'(1);
          rpt_valid_d = 1'b0;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (!any_blk) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      state_d     = StReport;
      pcnt_d      = '0;
      rpt_mask_d  = block_sigs_i;
      rpt_idx_d   = pick_idx;
      rpt_valid_d = 1'b1;
    end

    // A capture in the same cycle as clear keeps the flag set.
    if (capture) begin
      deadlock_d = 1'b1;
    end else if (clear_i) begin
      deadlock_d = 1'b0;
    end else begin
      deadlock_d = deadlock_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pcnt_q      <= '0;
      rr_ptr_q    <= '0;
      rpt_idx_q   <= '0;
      rpt_mask_q  <= '0;
      rpt_valid_q <= 1'b0;
      deadlock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rpt_idx_q   <= rpt_idx_d;
      rpt_mask_q  <= rpt_mask_d;
      rpt_valid_q <= rpt_valid_d;
      deadlock_q  <= deadlock_d;
    end
  end

  assign rpt_valid_o = rpt_valid_q;
  assign rpt_idx_o   = rpt_idx_q;
  assign rpt_mask_o  = rpt_mask_q;
  assign deadlock_o  = deadlock_q;

`ifdef DEADLOCK_DURATION_EN
  logic [CNT_W-1:0] dur_q, dur_d, dur_inc;
  logic [CNT_W-1:0] rpt_cycles_q, rpt_cycles_d;

  // dur_inc counts the current cycle, so a capture sees the full run length.
  assign dur_inc      = (dur_q == '1) ? dur_q : dur_q + CNT_W'(1);
  assign dur_d        = any_blk ? dur_inc : '0;
  assign rpt_cycles_d = capture ? dur_inc : rpt_cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dur_q        <= '0;
      rpt_cycles_q <= '0;
    end else begin
      dur_q        <= dur_d;
      rpt_cycles_q <= rpt_cycles_d;
    end
  end

  assign rpt_cycles_o = rpt_cycles_q;
`else
  // Duration tracking not built; report path carries index and mask only.
`endif

endmodule

// File: tb/tb_gp_deadlock_report_ctrl.sv
// Self-checking bench for gp_deadlock_report_ctrl: vector table plus report scoreboard.
module tb_gp_deadlock_report_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] block_sigs = '0;
  logic       clear = 1'b0;
  logic       rpt_ready = 1'b1;
  logic       rpt_valid;
  logic [2:0] rpt_idx;
  logic [7:0] rpt_mask;
  logic       deadlock;
`ifdef DEADLOCK_DURATION_EN
  logic [15:0] rpt_cycles;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  idx;
    logic [7:0]  mask;
    logic [15:0] cyc;
  } rpt_t;

  typedef struct {
    logic       en;
    logic [7:0] blk;
    int         hold;
    logic       exp_rpt;
    logic [2:0] exp_idx;
    logic [7:0] exp_mask;
    logic       exp_dl;
  } vec_t;

  rpt_t sb_q[$];
  logic prev_valid = 1'b0;

  gp_deadlock_report_ctrl #(
    .N_MON         (8),
    .IDX_W         (3),
    .PERSIST_CYCLES(16),
    .CNT_W         (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .block_sigs_i(block_sigs),
    .clear_i     (clear),
    .rpt_valid_o (rpt_valid),
    .rpt_ready_i (rpt_ready),
    .rpt_idx_o   (rpt_idx),
    .rpt_mask_o  (rpt_mask),
`ifdef DEADLOCK_DURATION_EN
    .rpt_cycles_o(rpt_cycles),
`endif
    .deadlock_o  (deadlock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every new report must match the oldest expected one.
  always @(negedge clk) begin
    if (rpt_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_report", {29'b0, rpt_idx}, 32'hFFFF_FFFF);
      end else begin
        rpt_t e;
        e = sb_q.pop_front();
        chk("rpt_idx", {29'b0, rpt_idx}, {29'b0, e.idx});
        chk("rpt_mask", {24'b0, rpt_mask}, {24'b0, e.mask});
`ifdef DEADLOCK_DURATION_EN
        chk("rpt_cycles", {16'b0, rpt_cycles}, {16'b0, e.cyc});
`endif
      end
    end
    prev_valid = rpt_valid;
  end

  vec_t vecs[10];

  initial begin
    // Expected indices follow the round-robin pointer from reset (0).
    vecs[0] = '{1'b1, 8'h04, 15, 1'b0, 3'd0, 8'h00, 1'b0};  // too short, ptr 0
    vecs[1] = '{1'b1, 8'h24, 16, 1'b1, 3'd2, 8'h24, 1'b1};  // ptr 0 -> 3
    vecs[2] = '{1'b1, 8'h24, 20, 1'b1, 3'd5, 8'h24, 1'b1};  // ptr 3 -> 6
    vecs[3] = '{1'b1, 8'h24, 16, 1'b1, 3'd2, 8'h24, 1'b1};  // wrap, ptr 6 -> 3
    vecs[4] = '{1'b1, 8'h81, 16, 1'b1, 3'd7, 8'h81, 1'b1};  // ptr 3 -> 0
    vecs[5] = '{1'b1, 8'h81, 17, 1'b1, 3'd0, 8'h81, 1'b1};  // ptr 0 -> 1
    vecs[6] = '{1'b1, 8'h04, 16, 1'b1, 3'd2, 8'h04, 1'b1};  // ptr 1 -> 3
    vecs[7] = '{1'b1, 8'hFF, 30, 1'b1, 3'd3, 8'hFF, 1'b1};  // ptr 3 -> 4
    vecs[8] = '{1'b1, 8'h10, 1,  1'b0, 3'd0, 8'h00, 1'b1};
    vecs[9] = '{1'b0, 8'hFF, 20, 1'b0, 3'd0, 8'h00, 1'b1};  // disabled

    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", {31'b0, rpt_valid}, 32'd0);
    chk("reset_idx", {29'b0, rpt_idx}, 32'd0);
    chk("reset_mask", {24'b0, rpt_mask}, 32'd0);
    chk("reset_deadlock", {31'b0, deadlock}, 32'd0);
    cyc(1);

    for (int i = 0; i < 10; i++) begin
      enable = vecs[i].en;
      block_sigs = vecs[i].blk;
      if (vecs[i].exp_rpt) sb_q.push_back('{vecs[i].exp_idx, vecs[i].exp_mask, 16'd16});
      cyc(vecs[i].hold);
      block_sigs = '0;
      enable = 1'b1;
      cyc(3);
      chk($sformatf("tbl%0d_deadlock", i), {31'b0, deadlock}, {31'b0, vecs[i].exp_dl});
      chk($sformatf("tbl%0d_pending", i), sb_q.size(), 32'd0);
    end

    // Backpressure: report held while block_sigs moves; ptr 4 -> idx 5.
    rpt_ready = 1'b0;
    block_sigs = 8'h24;
    sb_q.push_back('{3'd5, 8'h24, 16'd16});
    cyc(16);
    for (int k = 0; k < 10; k++) begin
      block_sigs = k[0] ? 8'h03 : 8'hC0;
      @(negedge clk);
      chk("bp_valid", {31'b0, rpt_valid}, 32'd1);
      chk("bp_idx", {29'b0, rpt_idx}, 32'd5);
      chk("bp_mask", {24'b0, rpt_mask}, 32'h24);
      @(posedge clk);
      #1;
    end
    rpt_ready = 1'b1;
    block_sigs = 8'h01;
    cyc(1);
    cyc(20);
    chk("hold_no_report", {31'b0, rpt_valid}, 32'd0);
    block_sigs = '0;
    cyc(2);
    chk("bp_pending", sb_q.size(), 32'd0);

    // clear alone, then clear colliding with a capture; ptr 6 -> idx 2.
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    @(negedge clk);
    chk("clear_alone", {31'b0, deadlock}, 32'd0);
    block_sigs = 8'h04;
    sb_q.push_back('{3'd2, 8'h04, 16'd16});
    cyc(15);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    @(negedge clk);
    chk("clear_vs_capture", {31'b0, deadlock}, 32'd1);
    block_sigs = '0;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    @(negedge clk);
    chk("clear_after", {31'b0, deadlock}, 32'd0);

    // Reset mid-REPORT drops the report and restores the pointer; ptr 3 -> idx 6.
    rpt_ready = 1'b0;
    block_sigs = 8'h40;
    sb_q.push_back('{3'd6, 8'h40, 16'd16});
    cyc(16);
    @(negedge clk);
    chk("pre_reset_valid", {31'b0, rpt_valid}, 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    block_sigs = '0;
    @(negedge clk);
    chk("rst_mid_valid", {31'b0, rpt_valid}, 32'd0);
    chk("rst_mid_idx", {29'b0, rpt_idx}, 32'd0);
    chk("rst_mid_mask", {24'b0, rpt_mask}, 32'd0);
    chk("rst_mid_deadlock", {31'b0, deadlock}, 32'd0);
`ifdef DEADLOCK_DURATION_EN
    chk("rst_mid_cycles", {16'b0, rpt_cycles}, 32'd0);
`endif
    rpt_ready = 1'b1;
    block_sigs = 8'h21;
    sb_q.push_back('{3'd0, 8'h21, 16'd16});
    cyc(16);
    block_sigs = '0;
    cyc(3);
    chk("post_rst_pending", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
